// File: rtl/vga_scan_addr.sv
// Raster scan generator: pixel/line counters, registered linear pixel address,
// active-low syncs, blank, frame tick, and a frame-synchronous origin shadow
// register that only updates at the start of vertical blank.
module vga_scan_addr #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        iVGA_CLK,
  input  logic        iRST_n,
  input  logic [18:0] iStartAddr,
  input  logic        iStartLoad,
  output logic [18:0] oAddr,
  output logic [18:0] oStartAddr,
  output logic        oHS,
  output logic        oVS,
  output logic        oBLANK_n,
  output logic        oFrameTick,
  output logic        oLoadRej
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] HS_END = HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(V_VISIBLE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] VS_END = VW'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [18:0]   ADDR_MAX = 19'(H_VISIBLE * V_VISIBLE - 1);

  logic          run;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [18:0]   addr_cnt;
  logic [18:0]   pend;
  logic          pend_valid;

  logic visible, hs_act, vs_act, frame_end, commit_pt, load_ok;

  // Decode of the current counter position; everything downstream registers it.
  always_comb begin
    visible   = (hcnt < H_VIS) && (vcnt < V_VIS);
    hs_act    = (hcnt >= HS_BEG) && (hcnt < HS_END);
    vs_act    = (vcnt >= VS_BEG) && (vcnt < VS_END);
    frame_end = (hcnt == H_LAST) && (vcnt == V_LAST);
    commit_pt = run && (hcnt == '0) && (vcnt == V_VIS);
    load_ok   = iStartLoad && (iStartAddr <= ADDR_MAX);
  end

  // Holds the scan at (0,0) for the first edge after reset release.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) run <= 1'b0;
    else         run <= 1'b1;
  end

  // Horizontal and vertical position counters.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (run) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        if (vcnt == V_LAST) vcnt <= '0;
        else                vcnt <= vcnt + VW'(1);
      end else begin
        hcnt <= hcnt + HW'(1);
      end
    end
  end

  // Incremental pixel address plus the aligned sync/blank/tick outputs.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      addr_cnt   <= '0;
      oAddr      <= '0;
      oBLANK_n   <= 1'b0;
      oHS        <= 1'b1;
      oVS        <= 1'b1;
      oFrameTick <= 1'b0;
    end else if (run) begin
      if (frame_end)    addr_cnt <= '0;
      else if (visible) addr_cnt <= addr_cnt + 19'd1;
      if (visible) oAddr <= addr_cnt;
      oBLANK_n   <= visible;
      oHS        <= ~hs_act;
      oVS        <= ~vs_act;
      oFrameTick <= commit_pt;
    end
  end

  // Origin shadow: a load issued in the commit cycle lands after the commit,
  // so it stays pending for the following frame.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      pend       <= '0;
      pend_valid <= 1'b0;
      oStartAddr <= '0;
      oLoadRej   <= 1'b0;
    end else begin
      oLoadRej <= iStartLoad && !load_ok;
      if (commit_pt && pend_valid) begin
        oStartAddr <= pend;
        pend_valid <= 1'b0;
      end
      if (load_ok) begin
        pend       <= iStartAddr;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_addr.sv
// Bench for vga_scan_addr: a full-size 640x480 instance checked over its first
// lines, and a reduced-timing instance checked over whole frames, both against
// an arithmetic position-based reference model.
module tb_vga_scan_addr;

  localparam int SHV = 64, SHF = 4, SHS = 8, SHB = 4;
  localparam int SVV = 48, SVF = 2, SVS = 2, SVB = 3;
  localparam int SHT = SHV + SHF + SHS + SHB;
  localparam int COMMIT_POS = SVV * SHT;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic        rst_n, load;
  logic [18:0] laddr;
  logic [18:0] s_addr, s_start, f_addr, f_start;
  logic        s_hs, s_vs, s_blank, s_tick, s_rej;
  logic        f_hs, f_vs, f_blank, f_tick, f_rej;

  vga_scan_addr #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
  ) dut_s (
    .iVGA_CLK(clk), .iRST_n(rst_n), .iStartAddr(laddr), .iStartLoad(load),
    .oAddr(s_addr), .oStartAddr(s_start), .oHS(s_hs), .oVS(s_vs),
    .oBLANK_n(s_blank), .oFrameTick(s_tick), .oLoadRej(s_rej)
  );

  vga_scan_addr dut_f (
    .iVGA_CLK(clk), .iRST_n(rst_n), .iStartAddr(laddr), .iStartLoad(load),
    .oAddr(f_addr), .oStartAddr(f_start), .oHS(f_hs), .oVS(f_vs),
    .oBLANK_n(f_blank), .oFrameTick(f_tick), .oLoadRej(f_rej)
  );

  typedef struct {
    int pos;
    bit started;
    int addr, start, pend;
    bit pv, blank, hs, vs, tick, rej;
  } model_t;

  function automatic model_t model_reset();
    model_t m;
    m.pos = 0; m.started = 0; m.addr = 0; m.start = 0; m.pend = 0; m.pv = 0;
    m.blank = 0; m.hs = 1; m.vs = 1; m.tick = 0; m.rej = 0;
    return m;
  endfunction

  // Scan position pos = v*line_total + h; outputs derived with plain arithmetic.
  function automatic model_t model_step(model_t m, bit ld, int la,
      int hv, int hf, int hsw, int hb, int vv, int vf, int vsw, int vb);
    int ht, vt, h, v;
    bit at_commit;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    h = m.pos % ht;
    v = m.pos / ht;
    at_commit = m.started && h == 0 && v == vv;
    if (at_commit && m.pv) begin
      m.start = m.pend;
      m.pv = 0;
    end
    m.rej = ld && (la > hv * vv - 1);
    if (ld && !m.rej) begin
      m.pend = la;
      m.pv = 1;
    end
    if (!m.started) begin
      m.started = 1;
    end else begin
      m.blank = (h < hv) && (v < vv);
      m.hs = !(h >= hv + hf && h < hv + hf + hsw);
      m.vs = !(v >= vv + vf && v < vv + vf + vsw);
      m.tick = (h == 0) && (v == vv);
      if (m.blank) m.addr = v * hv + h;
      m.pos = (m.pos + 1) % (ht * vt);
    end
    return m;
  endfunction

  model_t ms, mf;
  int n_pass = 0, n_total = 0;
  int mm_s = 0, mm_f = 0;
  int ecnt = 0;

  task automatic check(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic compare();
    if (s_addr !== 19'(ms.addr) || s_start !== 19'(ms.start) || s_hs !== ms.hs ||
        s_vs !== ms.vs || s_blank !== ms.blank || s_tick !== ms.tick || s_rej !== ms.rej)
      mm_s++;
    if (f_addr !== 19'(mf.addr) || f_start !== 19'(mf.start) || f_hs !== mf.hs ||
        f_vs !== mf.vs || f_blank !== mf.blank || f_tick !== mf.tick || f_rej !== mf.rej)
      mm_f++;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) begin
      ms = model_step(ms, load, int'(laddr), SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB);
      mf = model_step(mf, load, int'(laddr), 640, 16, 96, 48, 480, 10, 2, 33);
      ecnt++;
    end else begin
      ms = model_reset();
      mf = model_reset();
    end
    @(negedge clk);
    compare();
  endtask

  task automatic apply_reset(int n);
    rst_n = 1'b0;
    #1;
    ms = model_reset();
    mf = model_reset();
    compare();
    check("rst_s_addr", s_addr, 0);
    check("rst_s_start", s_start, 0);
    check("rst_s_hs", s_hs, 1);
    check("rst_s_vs", s_vs, 1);
    check("rst_s_blank", s_blank, 0);
    check("rst_s_tick", s_tick, 0);
    check("rst_s_rej", s_rej, 0);
    check("rst_f_addr", f_addr, 0);
    check("rst_f_blank", f_blank, 0);
    for (int i = 0; i < n; i++) cycle();
    rst_n = 1'b1;
    ecnt = 0;
  endtask

  task automatic run_to_commit(output bit ok);
    ok = 0;
    for (int i = 0; i < 5000; i++) begin
      if (ms.started && ms.pos == COMMIT_POS) begin
        ok = 1;
        break;
      end
      cycle();
    end
  endtask

  typedef struct {
    bit full;
    int x, y;
    int exp_addr;
    bit exp_blank;
  } vec_t;

  vec_t vt[13];
  bit ok;
  int cnt_a, cnt_b, first;

  initial begin
    rst_n = 1'b0; load = 1'b0; laddr = '0;
    ms = model_reset(); mf = model_reset();

    vt[0]  = '{0, 0, 0, 0, 1};
    vt[1]  = '{1, 0, 0, 0, 1};
    vt[2]  = '{0, 63, 0, 63, 1};
    vt[3]  = '{0, 70, 0, 63, 0};
    vt[4]  = '{0, 0, 1, 64, 1};
    vt[5]  = '{1, 639, 0, 639, 1};
    vt[6]  = '{1, 0, 1, 640, 1};
    vt[7]  = '{1, 700, 1, 1279, 0};
    vt[8]  = '{1, 5, 2, 1285, 1};
    vt[9]  = '{0, 10, 20, 1290, 1};
    vt[10] = '{0, 63, 47, 3071, 1};
    vt[11] = '{0, 0, 50, 3071, 0};
    vt[12] = '{0, 0, 55, 0, 1};

    @(negedge clk);
    apply_reset(5);
    cycle();
    check("edge1_s_blank", s_blank, 0);
    check("edge1_f_blank", f_blank, 0);

    // Address/blank at selected pixels (y=55 on the small scan is next frame row 0).
    for (int i = 0; i < 13; i++) begin
      int tgt;
      tgt = 2 + vt[i].y * (vt[i].full ? 800 : SHT) + vt[i].x;
      while (ecnt < tgt) cycle();
      check($sformatf("vec%0d_addr", i), vt[i].full ? int'(f_addr) : int'(s_addr), vt[i].exp_addr);
      check($sformatf("vec%0d_blank", i), vt[i].full ? int'(f_blank) : int'(s_blank), int'(vt[i].exp_blank));
    end

    // Full-size line timing.
    apply_reset(2);
    cycle(); cycle();
    cnt_a = 0; cnt_b = 0; first = -1;
    for (int i = 0; i < 800; i++) begin
      if (f_blank) cnt_a++;
      if (!f_hs) begin
        cnt_b++;
        if (first < 0) first = i;
      end
      cycle();
    end
    check("line_blank_cycles", cnt_a, 640);
    check("line_hs_cycles", cnt_b, 96);
    check("line_hs_offset", first, 656);
    check("line2_blank", f_blank, 1);
    check("line2_addr", f_addr, 640);

    // Small-scan frame: vsync width and one tick per frame.
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < SHT * 55; i++) begin
      if (!s_vs) cnt_a++;
      if (s_tick) cnt_b++;
      cycle();
    end
    check("frame_vs_cycles", cnt_a, SVS * SHT);
    check("frame_ticks", cnt_b, 1);

    // Origin commit.
    apply_reset(2);
    while (ecnt < 2 + 10 * SHT + 30) cycle();
    load = 1'b1; laddr = 19'd1000;
    cycle();
    load = 1'b0;
    cnt_a = 0;
    ok = 0;
    for (int i = 0; i < 5000; i++) begin
      if (ms.started && ms.pos == COMMIT_POS) begin
        ok = 1;
        break;
      end
      if (s_start != 19'd0) cnt_a++;
      cycle();
    end
    check("commit_reached", ok, 1);
    check("commit_early_changes", cnt_a, 0);
    cycle();
    check("commit_tick", s_tick, 1);
    check("commit_value", s_start, 1000);

    // Load collides with commit.
    for (int i = 0; i < 300; i++) cycle();
    load = 1'b1; laddr = 19'd2000;
    cycle();
    load = 1'b0;
    run_to_commit(ok);
    check("collide_reached", ok, 1);
    load = 1'b1; laddr = 19'd3000;
    cycle();
    load = 1'b0;
    check("collide_tick", s_tick, 1);
    check("collide_value_now", s_start, 2000);
    cycle();
    check("collide_hold", s_start, 2000);
    run_to_commit(ok);
    cycle();
    check("collide_value_next", s_start, 3000);

    // Rejection, boundary loads, then reset mid-frame.
    for (int i = 0; i < 300; i++) cycle();
    load = 1'b1; laddr = 19'd500;
    cycle();
    check("load500_rej", s_rej, 0);
    laddr = 19'd3072;
    cycle();
    check("rej3072_s", s_rej, 1);
    check("rej3072_f", f_rej, 0);
    load = 1'b0;
    cycle();
    check("rej_pulse_end", s_rej, 0);
    load = 1'b1; laddr = 19'd307200;
    cycle();
    load = 1'b0;
    check("rej307200_f", f_rej, 1);
    check("rej307200_s", s_rej, 1);
    cycle();
    check("rej307200_end", f_rej, 0);
    run_to_commit(ok);
    cycle();
    check("rej_pending_kept", s_start, 500);
    for (int i = 0; i < 500; i++) cycle();
    load = 1'b1; laddr = 19'd777;
    cycle();
    load = 1'b0;
    for (int i = 0; i < 200; i++) cycle();
    apply_reset(2);
    cycle(); cycle();
    check("after_rst_addr", s_addr, 0);
    check("after_rst_blank", s_blank, 1);
    run_to_commit(ok);
    cycle();
    check("after_rst_tick", s_tick, 1);
    check("after_rst_pending_lost", s_start, 0);

    // Randomized loads against the reference model.
    apply_reset(2);
    for (int i = 0; i < 9000; i++) begin
      if ($urandom_range(0, 39) == 0 ||
          (ms.started && ms.pos == COMMIT_POS && $urandom_range(0, 1) == 1)) begin
        int sel;
        sel = int'($urandom_range(0, 3));
        load = 1'b1;
        case (sel)
          0: laddr = 19'($urandom_range(0, 3071));
          1: laddr = 19'd3071;
          2: laddr = 19'd3072;
          default: laddr = 19'($urandom_range(3073, 524287));
        endcase
      end else begin
        load = 1'b0;
      end
      cycle();
    end
    load = 1'b0;
    cycle();
    check("model_small_mismatch_cycles", mm_s, 0);
    check("model_full_mismatch_cycles", mm_f, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vga_scan_addr.md
# vga_scan_addr

Raster scan generator for the 640x480@60 Hz display path. It produces the linear pixel address (y*640+x), the sync signals and the blank signal consumed by the rectangle-hit comparators. It also provides a frame-synchronous shadow register for the rectangle origin address, so the comparators see one origin value for the whole of each visible frame.

## Interface
Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BACK, 48, horizontal back porch (line total 800)
- V_VISIBLE, 480, active lines
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BACK, 33, vertical back porch (frame total 525)

Ports:
- iVGA_CLK  in  1  pixel clock (25 MHz)
- iRST_n  in  1  asynchronous active-low reset
- iStartAddr  in  19  requested rectangle origin address
- iStartLoad  in  1  one-cycle strobe to capture iStartAddr
- oAddr  out  19  linear pixel address, registered
- oStartAddr  out  19  committed origin address, frame-stable
- oHS  out  1  horizontal sync, active low
- oVS  out  1  vertical sync, active low
- oBLANK_n  out  1  high during visible pixels
- oFrameTick  out  1  one-cycle pulse at the start of vertical blank
- oLoadRej  out  1  one-cycle pulse when a load is rejected

## Operation
- Counters:
  - hcnt counts 0..799 and wraps to 0.
  - vcnt advances when hcnt==799 and wraps 524 to 0.
- Visible region: hcnt<640 and vcnt<480.
- HS is low for hcnt 656..751. VS is low for vcnt 490..491.
- Address counter:
  - Increments by 1 on each visible pixel.
  - Cleared to 0 when (hcnt,vcnt)==(799,524).
  - The counter is incremental; no multiplier is used.
  - oAddr holds the last visible value during blanking.
  - Values: (0,0) gives 0, (639,0) gives 639, (0,1) gives 640, (639,479) gives 307199.
- Origin shadow:
  - iStartLoad with iStartAddr<=307199 writes a pending register and sets pend_valid.
  - iStartLoad with iStartAddr>307199 is ignored and pulses oLoadRej.
  - A later load overwrites the pending value (last writer wins).
- Commit: at (hcnt,vcnt)==(0,480), if pend_valid is set, oStartAddr takes the pending value and pend_valid clears.
- Load in the commit cycle:
  - The commit uses the pending value from before that cycle.
  - The new load becomes pending for the next frame, and pend_valid stays set.
- oStartAddr never changes outside the commit cycle.

## Timing
- Reset values (asynchronous, while iRST_n=0):
  - hcnt=0, vcnt=0, address counter=0.
  - oAddr=0, oStartAddr=0, pending=0, pend_valid=0.
  - oHS=1, oVS=1, oBLANK_n=0, oFrameTick=0, oLoadRej=0.
- Latency: oAddr, oHS, oVS, oBLANK_n and oFrameTick reflect the counter state of the previous cycle. All five stay mutually aligned, so the comparators need no extra delay.
- First clock after reset release: counters are at (0,0). On the second edge, oBLANK_n=1 and oAddr=0.
- oFrameTick is high in the output cycle for (0,480). oStartAddr takes the new value on that same edge.
- oLoadRej is high in the cycle after the rejected strobe.
- Reset asserted mid-frame: all state returns to reset values immediately. After release, the scan restarts at (0,0) and any pending origin is lost.
- Line = 800 cycles; frame = 420000 cycles.

## Test plan
- Reset check:
  - Stimulus: hold iRST_n=0 for 5 cycles, then release.
  - Response: all outputs at their reset values during reset. oBLANK_n rises 2 edges after release with oAddr=0.
- Line timing:
  - Stimulus: run one line.
  - Response: oBLANK_n high for exactly 640 cycles. oHS low for exactly 96 cycles, starting 656 cycles after blank rises. Line period 800.
- Address sweep:
  - Stimulus: run one full frame.
  - Response: oAddr reads 639, 640 and 307199 at the stated pixels. oAddr=0 on the first visible pixel of the next frame. oVS is low for 1600 cycles.
- Origin commit:
  - Stimulus: load 1000 mid-frame at line 100.
  - Response: oStartAddr stays 0 until the oFrameTick cycle, then reads 1000.
- Load collides with commit:
  - Stimulus: pending=2000; load 3000 in the commit cycle.
  - Response: oStartAddr=2000 this frame and 3000 at the next oFrameTick.
- Rejection and reset:
  - Stimulus: load 307200, then assert reset mid-frame.
  - Response: oLoadRej pulses once and the pending value is unchanged. After reset, oStartAddr=0 and oAddr=0.
